mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The parameter list SHALL be: MAX_OP_BURST, default 2, the maximum number of consecutive operand grants while a fetch request is pending.
REQ-002 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 if_req  input  1  instruction-fetch request, held until if_done.
REQ-006 if_addr  input  16  fetch byte address, stable while if_req is high.
REQ-007 if_gnt  output  1  one-cycle pulse when the fetch request is accepted.
REQ-008 if_done  output  1  one-cycle pulse; if_rdata is valid in the same cycle.
REQ-009 if_rdata  output  16  fetched word, {mem[a], mem[a+1]}.
REQ-010 op_req  input  1  operand request, held until op_done or op_err.
REQ-011 op_addr  input  16  operand byte address.
REQ-012 op_we  input  1  1 = write, 0 = read.
REQ-013 op_byte  input  1  1 = byte access, 0 = word access.
REQ-014 op_wdata  input  16  write data; a byte write uses bits 7:0.
REQ-015 op_gnt, op_done, op_err  output  1 each  grant pulse, completion pulse, and odd-word-address error pulse.
REQ-016 op_rdata  output  16  read data; a byte read is zero-extended.
REQ-017 mem_en, mem_we  output  1 each  byte-memory strobe and write enable.
REQ-018 mem_addr  output  16  byte address.
REQ-019 mem_wdata  output  8  byte memory write data.
REQ-020 mem_rdata  input  8  read data, valid the cycle after mem_en with mem_we=0.
REQ-021 busy  output  1  high in every state other than IDLE.

Function
REQ-022 The FSM SHALL have exactly four states: IDLE, BYTE0, BYTE1 and DONE.
REQ-023 IDLE SHALL arbitrate among the requests that are high, pulse the winner's gnt, and latch its address, data, we and byte controls.
REQ-024 IDLE SHALL go to BYTE0 when a request is granted.
REQ-025 Arbitration: operand SHALL win over fetch, except that after MAX_OP_BURST consecutive operand grants with if_req high, fetch SHALL win.
REQ-026 The burst counter SHALL clear on any fetch grant and on any cycle in IDLE with if_req low.
REQ-027 An operand word access (op_byte=0) with op_addr[0]=1 SHALL be granted, pulse op_err in the grant cycle, and stay in IDLE with no mem_en.
REQ-028 A fetch with if_addr[0]=1 SHALL be treated as an even address (bit 0 forced to 0) and SHALL NOT flag an error.
REQ-029 BYTE0 SHALL drive mem_en=1 and mem_addr=A; a write drives wdata[15:8] for a word or wdata[7:0] for a byte.
REQ-030 BYTE0 SHALL go to BYTE1 for a word access and to DONE for a byte access.
REQ-031 BYTE1 SHALL drive mem_en=1 and mem_addr=A+1 (16-bit wrap), with wdata[7:0] on a write.
REQ-032 BYTE1 SHALL capture mem_rdata as the high byte.
REQ-033 DONE SHALL capture the low byte, or the only byte for a byte access, pulse the owner's done with rdata valid, and return to IDLE.
REQ-034 Latency from grant to done SHALL be 3 cycles for a word access and 2 cycles for a byte access.
REQ-035 The next grant SHALL occur in the cycle after DONE.
REQ-036 Write accesses SHALL still pulse done; rdata is then don't-care.
REQ-037 Dropping req mid-access SHALL NOT abort the access; done still pulses.
REQ-038 Outside BYTE0 and BYTE1, mem_en and mem_we SHALL be 0.
REQ-039 rdata outputs SHALL hold their last value until the next done.

Reset
REQ-040 On reset_n low, asynchronously: state = IDLE, burst counter = 0, and all gnt, done, err, mem_en, mem_we and busy outputs = 0.
REQ-041 On reset, mem_addr, mem_wdata, if_rdata and op_rdata SHALL be 16'h0000 or 8'h00 according to width.
REQ-042 Reset mid-access SHALL abandon the access with no done pulse; a requester re-requests after reset.

Structure
REQ-043 The arb_state_t enum, the requester enum (REQ_IF, REQ_OP) and the MAX_OP_BURST default constant SHALL live in the shared parameters package.
REQ-044 No sub-module SHALL be used; arbitration and the byte sequencer are one module.

Verification
REQ-045 Word read: mem[0x0100]=0x12, mem[0x0101]=0x34, fetch of 0x0100 -> if_gnt at T, if_done at T+3, if_rdata=0x1234.
REQ-046 Byte write: op_we=1, op_byte=1, op_addr=0x0203, op_wdata=0xABCD -> one mem write of 0xCD to 0x0203; op_done 2 cycles after grant.
REQ-047 Odd word access: op_addr=0x0201, op_byte=0 -> op_err pulse, no mem_en, FSM stays in IDLE.
REQ-048 Starvation guard: if_req and op_req held continuously with MAX_OP_BURST=2 -> grant order OP, OP, IF, OP, OP, IF.
REQ-049 Reset mid-access: reset_n low during BYTE1 -> immediately IDLE, mem_en=0, no done pulse; a new request after reset completes normally.
REQ-050 Wrap: byte read at 0xFFFF followed by word read at 0x0000 -> correct data for both, no error.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester byte-memory arbiter.
package mem_port_arbiter_pkg;

    // Arbiter / byte sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Owner of the access currently in flight.
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_OP = 1'b1
    } req_sel_t;

    // Default number of back-to-back operand grants allowed while fetch waits.
    localparam int unsigned MAX_OP_BURST_DEFAULT = 2;

    // Width of a counter that must hold values 0..max_burst.
    function automatic int unsigned burst_cnt_width(input int unsigned max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and an operand port onto a single
// byte-wide memory, sequencing 16-bit words as two big-endian byte accesses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OP_BURST = MAX_OP_BURST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    // instruction fetch port
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [15:0] if_rdata,
    // operand port
    input  logic        op_req,
    input  logic [15:0] op_addr,
    input  logic        op_we,
    input  logic        op_byte,
    input  logic [15:0] op_wdata,
    output logic        op_gnt,
    output logic        op_done,
    output logic        op_err,
    output logic [15:0] op_rdata,
    // byte memory port
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);

    localparam int unsigned     CW          = burst_cnt_width(MAX_OP_BURST);
    localparam logic [CW-1:0]   BURST_LIMIT = CW'(MAX_OP_BURST);

    arb_state_t     r_state;
    arb_state_t     w_next_state;
    req_sel_t       r_owner;
    logic [15:0]    r_addr;
    logic [15:0]    r_wdata;
    logic           r_we;
    logic           r_byte;
    logic [7:0]     r_hi;
    logic [CW-1:0]  r_burst;
    logic [15:0]    r_if_rdata;
    logic [15:0]    r_op_rdata;

    logic           w_arb_en;
    logic           w_op_wins;
    logic           w_if_wins;
    logic           w_op_odd;
    logic [15:0]    w_rdata;

    // Arbitration: operand first unless fetch has waited through a full burst.
    // Gated by reset_n so no grant or error can pulse while reset is held.
    always_comb begin
        w_arb_en  = reset_n && (r_state == IDLE);
        w_op_wins = w_arb_en && op_req && !(if_req && (r_burst >= BURST_LIMIT));
        w_if_wins = w_arb_en && if_req && !w_op_wins;
        w_op_odd  = w_op_wins && !op_byte && op_addr[0];
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state memory / handshake outputs.
    always_comb begin
        w_next_state = r_state;
        if_gnt       = 1'b0;
        op_gnt       = 1'b0;
        op_err       = 1'b0;
        if_done      = 1'b0;
        op_done      = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = r_addr;
        mem_wdata    = r_wdata[7:0];
        busy         = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if_gnt = w_if_wins;
                op_gnt = w_op_wins;
                op_err = w_op_odd;
                if (w_if_wins || (w_op_wins && !w_op_odd)) begin
                    w_next_state = BYTE0;
                end
            end
            BYTE0: begin
                mem_en       = 1'b1;
                mem_we       = r_we;
                mem_wdata    = r_byte ? r_wdata[7:0] : r_wdata[15:8];
                w_next_state = r_byte ? DONE : BYTE1;
            end
            BYTE1: begin
                mem_en       = 1'b1;
                mem_we       = r_we;
                mem_addr     = r_addr + 16'd1;
                w_next_state = DONE;
            end
            DONE: begin
                if_done      = (r_owner == REQ_IF);
                op_done      = (r_owner == REQ_OP);
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Latch the winning request's controls at grant time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner <= REQ_IF;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
        end else if (w_op_wins) begin
            r_owner <= REQ_OP;
            r_addr  <= op_addr;
            r_wdata <= op_wdata;
            r_we    <= op_we;
            r_byte  <= op_byte;
        end else if (w_if_wins) begin
            r_owner <= REQ_IF;
            r_addr  <= if_addr & 16'hFFFE;
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
        end
    end

    // Burst counter: counts operand grants that made a waiting fetch lose.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_burst <= '0;
        end else if (w_if_wins || ((r_state == IDLE) && !if_req)) begin
            r_burst <= '0;
        end else if (w_op_wins && if_req && (r_burst < BURST_LIMIT)) begin
            r_burst <= r_burst + 1'b1;
        end
    end

    // High byte arrives in BYTE1 (read data lags mem_en by one cycle).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi <= '0;
        end else if (r_state == BYTE1) begin
            r_hi <= mem_rdata;
        end
    end

    // Assembled read word; the low (or only) byte is live on mem_rdata in DONE.
    always_comb begin
        w_rdata = r_byte ? {8'h00, mem_rdata} : {r_hi, mem_rdata};
    end

    // Hold registers keep the last delivered word between completions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_if_rdata <= '0;
            r_op_rdata <= '0;
        end else if (r_state == DONE) begin
            if (r_owner == REQ_IF) begin
                r_if_rdata <= w_rdata;
            end else begin
                r_op_rdata <= w_rdata;
            end
        end
    end

    // rdata is valid combinationally in the done cycle, then held.
    always_comb begin
        if_rdata = ((r_state == DONE) && (r_owner == REQ_IF)) ? w_rdata : r_if_rdata;
        op_rdata = ((r_state == DONE) && (r_owner == REQ_OP)) ? w_rdata : r_op_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a byte-memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        op_req;
    logic [15:0] op_addr;
    logic        op_we;
    logic        op_byte;
    logic [15:0] op_wdata;
    logic        op_gnt;
    logic        op_done;
    logic        op_err;
    logic [15:0] op_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    mem_port_arbiter #(.MAX_OP_BURST(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .op_req    (op_req),
        .op_addr   (op_addr),
        .op_we     (op_we),
        .op_byte   (op_byte),
        .op_wdata  (op_wdata),
        .op_gnt    (op_gnt),
        .op_done   (op_done),
        .op_err    (op_err),
        .op_rdata  (op_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Byte memory model with a bench-side preload port.
    logic [7:0]  mem [0:65535];
    logic [7:0]  rd_q = 8'h00;
    int          wr_count = 0;
    logic        tb_we = 1'b0;
    logic [15:0] tb_waddr = 16'h0;
    logic [7:0]  tb_wdata = 8'h0;

    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                wr_count      <= wr_count + 1;
            end else begin
                rd_q <= mem[mem_addr];
            end
        end
    end
    assign mem_rdata = rd_q;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we    = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    // Issue one request, drop it right after the grant, and time the completion.
    task automatic do_access(input bit is_op, input bit we, input bit byt,
                             input logic [15:0] addr, input logic [15:0] wd,
                             output logic [15:0] rd, output logic [15:0] rd_next,
                             output bit err, output int lat, output bit done_again,
                             output bit wrong_gnt, output bit stayed_idle, output bit ok);
        bit granted;
        rd = '0; rd_next = '0; err = 0; lat = 0; done_again = 0;
        wrong_gnt = 0; stayed_idle = 0; ok = 0; granted = 0;
        @(negedge clk);
        if (is_op) begin
            op_req = 1'b1; op_we = we; op_byte = byt; op_addr = addr; op_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int t = 0; t < 20; t++) begin
            #1;
            if (is_op ? op_gnt : if_gnt) begin
                granted   = 1;
                err       = op_err;
                wrong_gnt = is_op ? if_gnt : (op_gnt | op_err);
                stayed_idle = !mem_en;
                break;
            end
            @(negedge clk);
        end
        if (!granted) begin
            op_req = 1'b0; if_req = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        op_req = 1'b0;
        if_req = 1'b0;
        if (err) begin
            @(negedge clk);
            #1;
            stayed_idle = stayed_idle && !busy && !mem_en;
            ok = 1;
            return;
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            #1;
            lat++;
            if (is_op ? op_done : if_done) begin
                rd = is_op ? op_rdata : if_rdata;
                ok = 1;
                break;
            end
        end
        if (ok) begin
            @(negedge clk);
            #1;
            done_again = is_op ? op_done : if_done;
            rd_next    = is_op ? op_rdata : if_rdata;
        end
    endtask

    typedef struct {
        bit          is_op;
        bit          we;
        bit          byt;
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          chk_rd;
        logic [15:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
        int          exp_writes;
    } vec_t;

    function automatic vec_t mk(bit is_op, bit we, bit byt, logic [15:0] addr,
                                logic [15:0] wdata, bit chk_rd, logic [15:0] exp_rd,
                                bit exp_err, int exp_lat, int exp_writes);
        vec_t v;
        v.is_op = is_op; v.we = we; v.byt = byt; v.addr = addr; v.wdata = wdata;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_err = exp_err;
        v.exp_lat = exp_lat; v.exp_writes = exp_writes;
        return v;
    endfunction

    localparam int NV = 11;
    vec_t vecs [NV];

    logic [15:0] g_rd, g_rd_next;
    bit          g_err, g_done_again, g_wrong, g_idle, g_ok;
    int          g_lat, w_before;
    int          order [$];
    bit          both_gnt;
    int          seen_done;

    initial begin
        //        op we by addr      wdata     chkrd exp_rd    err lat wr
        vecs[0]  = mk(0, 0, 0, 16'h0100, 16'h0000, 1, 16'h1234, 0, 3, 0);
        vecs[1]  = mk(0, 0, 0, 16'h0101, 16'h0000, 1, 16'h1234, 0, 3, 0);
        vecs[2]  = mk(1, 1, 1, 16'h0203, 16'hABCD, 0, 16'h0000, 0, 2, 1);
        vecs[3]  = mk(1, 0, 1, 16'h0203, 16'h0000, 1, 16'h00CD, 0, 2, 0);
        vecs[4]  = mk(1, 1, 0, 16'h0300, 16'hBEEF, 0, 16'h0000, 0, 3, 2);
        vecs[5]  = mk(1, 0, 0, 16'h0300, 16'h0000, 1, 16'hBEEF, 0, 3, 0);
        vecs[6]  = mk(1, 0, 0, 16'h0201, 16'h0000, 0, 16'h0000, 1, 0, 0);
        vecs[7]  = mk(1, 0, 1, 16'hFFFF, 16'h0000, 1, 16'h005A, 0, 2, 0);
        vecs[8]  = mk(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h7788, 0, 3, 0);
        vecs[9]  = mk(0, 0, 0, 16'hFFFF, 16'h0000, 1, 16'h115A, 0, 3, 0);
        vecs[10] = mk(1, 1, 0, 16'h0301, 16'h1111, 0, 16'h0000, 1, 0, 0);

        // Reset state, with requests asserted to show nothing leaks through.
        reset_n = 1'b0;
        if_req = 1'b1; if_addr = 16'h0100;
        op_req = 1'b1; op_addr = 16'h0201; op_we = 1'b1; op_byte = 1'b0; op_wdata = 16'hFFFF;
        #2;
        chk("reset_gnt_err", {29'd0, if_gnt, op_gnt, op_err}, 32'd0);
        chk("reset_done", {30'd0, if_done, op_done}, 32'd0);
        chk("reset_mem_ctrl", {29'd0, mem_en, mem_we, busy}, 32'd0);
        chk("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("reset_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("reset_rdata", {if_rdata, op_rdata}, 32'd0);
        if_req = 1'b0; op_req = 1'b0;

        poke(16'h0100, 8'h12);
        poke(16'h0101, 8'h34);
        poke(16'h0202, 8'h99);
        poke(16'hFFFF, 8'h5A);
        poke(16'h0000, 8'h77);
        poke(16'h0001, 8'h88);
        poke(16'hFFFE, 8'h11);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            w_before = wr_count;
            do_access(vecs[i].is_op, vecs[i].we, vecs[i].byt, vecs[i].addr, vecs[i].wdata,
                      g_rd, g_rd_next, g_err, g_lat, g_done_again, g_wrong, g_idle, g_ok);
            chk($sformatf("v%0d_complete", i), {31'd0, g_ok}, 32'd1);
            chk($sformatf("v%0d_err", i), {31'd0, g_err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_other_gnt", i), {31'd0, g_wrong}, 32'd0);
            chk($sformatf("v%0d_writes", i), wr_count - w_before, vecs[i].exp_writes);
            if (vecs[i].exp_err) begin
                chk($sformatf("v%0d_stay_idle", i), {31'd0, g_idle}, 32'd1);
            end else begin
                chk($sformatf("v%0d_latency", i), g_lat, vecs[i].exp_lat);
                chk($sformatf("v%0d_done_pulse", i), {31'd0, g_done_again}, 32'd0);
            end
            if (vecs[i].chk_rd) begin
                chk($sformatf("v%0d_rdata", i), {16'd0, g_rd}, {16'd0, vecs[i].exp_rd});
                chk($sformatf("v%0d_rdata_hold", i), {16'd0, g_rd_next}, {16'd0, vecs[i].exp_rd});
            end
        end
        chk("mem_0203", {24'd0, mem[16'h0203]}, 32'hCD);
        chk("mem_0202_untouched", {24'd0, mem[16'h0202]}, 32'h99);
        chk("mem_0300", {24'd0, mem[16'h0300]}, 32'hBE);
        chk("mem_0301", {24'd0, mem[16'h0301]}, 32'hEF);

        // Starvation guard: both requests held continuously.
        @(negedge clk);
        op_req = 1'b1; op_we = 1'b0; op_byte = 1'b1; op_addr = 16'h0203;
        if_req = 1'b1; if_addr = 16'h0100;
        both_gnt = 0;
        for (int t = 0; t < 60; t++) begin
            #1;
            if (if_gnt && op_gnt) both_gnt = 1;
            if (op_gnt) order.push_back(1);
            else if (if_gnt) order.push_back(0);
            if (order.size() == 6) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        op_req = 1'b0; if_req = 1'b0;
        chk("starve_count", order.size(), 6);
        chk("starve_both_gnt", {31'd0, both_gnt}, 32'd0);
        if (order.size() == 6) begin
            chk("starve_order", {26'd0, order[0][0], order[1][0], order[2][0],
                                 order[3][0], order[4][0], order[5][0]}, 32'b110110);
        end
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        chk("starve_drain", {31'd0, busy}, 32'd0);

        // Reset during BYTE1 of an operand word read.
        @(negedge clk);
        op_req = 1'b1; op_we = 1'b0; op_byte = 1'b0; op_addr = 16'h0300;
        g_ok = 0;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (op_gnt) begin g_ok = 1; break; end
            @(negedge clk);
        end
        chk("rst_mid_grant", {31'd0, g_ok}, 32'd1);
        @(posedge clk);
        #1;
        op_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_in_byte1", {30'd0, mem_en, busy}, 32'b11);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_idle", {29'd0, busy, mem_en, mem_we}, 32'd0);
        chk("rst_mid_op_rdata", {16'd0, op_rdata}, 32'd0);
        seen_done = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (op_done || if_done || mem_en) seen_done++;
        end
        reset_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (op_done || if_done || busy) seen_done++;
        end
        chk("rst_mid_no_done", seen_done, 0);
        do_access(0, 0, 0, 16'h0100, 16'h0000, g_rd, g_rd_next, g_err, g_lat,
                  g_done_again, g_wrong, g_idle, g_ok);
        chk("after_rst_complete", {31'd0, g_ok}, 32'd1);
        chk("after_rst_latency", g_lat, 3);
        chk("after_rst_rdata", {16'd0, g_rd}, 32'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
